// File: rtl/rv_pkg.sv
// Shared branch encodings and helpers for the fetch/execute PC logic.
package rv_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_BEQ  = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;
    localparam logic [2:0] BR_BLT  = 3'b110;
    localparam logic [2:0] BR_BGE  = 3'b111;

    localparam int unsigned INSTR_BYTES = 4;

    // Codes that train the BTB; 000 and the reserved 011 do not.
    function automatic logic is_branch(input logic [2:0] br);
        return br inside {BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_JAL, BR_JALR};
    endfunction

endpackage

// File: rtl/rv_pc_predict_if.sv
// Fetch-side and execute-side signals of the PC prediction unit.
interface rv_pc_predict_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic [XLEN-1:0] if_pred_target;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [2:0]      ex_branch;
    logic            ex_zero;
    logic            ex_less;
    logic [XLEN-1:0] ex_rs;
    logic [XLEN-1:0] ex_imm;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;

    modport slave (
        input  stall, ex_valid, ex_pc, ex_branch, ex_zero, ex_less,
               ex_rs, ex_imm, ex_pred_taken, ex_pred_target,
        output if_pc, if_pred_taken, if_pred_target, redirect, redirect_pc, flush
    );

    modport master (
        output stall, ex_valid, ex_pc, ex_branch, ex_zero, ex_less,
               ex_rs, ex_imm, ex_pred_taken, ex_pred_target,
        input  if_pc, if_pred_taken, if_pred_target, redirect, redirect_pc, flush
    );

endinterface

// File: rtl/rv_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
module rv_btb #(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:2] i_rd_pc,
    output logic            o_rd_taken,
    output logic [XLEN-1:0] o_rd_target,
    input  logic            i_wr_en,
    input  logic [XLEN-1:2] i_wr_pc,
    input  logic            i_wr_taken,
    input  logic [XLEN-1:0] i_wr_target
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [BTB_DEPTH-1:0] r_valid;
    logic [1:0]           r_ctr    [BTB_DEPTH];
    logic [TAG_W-1:0]     r_tag    [BTB_DEPTH];
    logic [XLEN-1:0]      r_target [BTB_DEPTH];

    logic [IDX_W-1:0] w_rd_idx, w_wr_idx;
    logic [TAG_W-1:0] w_rd_tag, w_wr_tag;
    logic             w_rd_hit, w_wr_hit;

    assign w_rd_idx = i_rd_pc[IDX_W+1:2];
    assign w_rd_tag = i_rd_pc[XLEN-1:IDX_W+2];
    assign w_wr_idx = i_wr_pc[IDX_W+1:2];
    assign w_wr_tag = i_wr_pc[XLEN-1:IDX_W+2];

    assign w_rd_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign w_wr_hit    = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);
    assign o_rd_taken  = w_rd_hit && r_ctr[w_rd_idx][1];
    assign o_rd_target = o_rd_taken ? r_target[w_rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < BTB_DEPTH; i++) r_ctr[i] <= 2'b00;
        end else if (i_wr_en) begin
            if (i_wr_taken) begin
                if (!w_wr_hit) begin
                    r_valid[w_wr_idx] <= 1'b1;
                    r_ctr[w_wr_idx]   <= 2'b10;
                end else if (r_ctr[w_wr_idx] != 2'b11) begin
                    r_ctr[w_wr_idx] <= r_ctr[w_wr_idx] + 2'b01;
                end
            end else if (w_wr_hit && r_ctr[w_wr_idx] != 2'b00) begin
                r_ctr[w_wr_idx] <= r_ctr[w_wr_idx] - 2'b01;
            end
        end
    end

    // Tag/target need no reset: they are only observed through a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && i_wr_en && i_wr_taken) begin
            r_tag[w_wr_idx]    <= w_wr_tag;
            r_target[w_wr_idx] <= i_wr_target;
        end
    end

endmodule

// File: rtl/rv_pc_predict.sv
// Fetch PC register with BTB prediction and execute-stage branch resolution.
module rv_pc_predict
    import rv_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              BTB_DEPTH = 16,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input logic               clk,
    input logic               rst,
    rv_pc_predict_if.slave    bus
);
    logic [XLEN-1:0] r_pc;
    logic            w_pred_taken;
    logic [XLEN-1:0] w_pred_target;
    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_ex_pc4;
    logic [XLEN-1:0] w_actual;
    logic            w_mispredict;

    rv_btb #(
        .XLEN      (XLEN),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .i_rd_pc     (r_pc[XLEN-1:2]),
        .o_rd_taken  (w_pred_taken),
        .o_rd_target (w_pred_target),
        .i_wr_en     (bus.ex_valid && is_branch(bus.ex_branch)),
        .i_wr_pc     (bus.ex_pc[XLEN-1:2]),
        .i_wr_taken  (w_taken),
        .i_wr_target (w_target)
    );

    assign w_ex_pc4 = bus.ex_pc + XLEN'(INSTR_BYTES);

    always_comb begin
        w_taken  = 1'b0;
        w_target = bus.ex_pc + bus.ex_imm;
        case (bus.ex_branch)
            BR_BEQ:  w_taken = bus.ex_zero;
            BR_BNE:  w_taken = !bus.ex_zero;
            BR_BLT:  w_taken = bus.ex_less;
            BR_BGE:  w_taken = !bus.ex_less;
            BR_JAL:  w_taken = 1'b1;
            BR_JALR: begin
                w_taken  = 1'b1;
                w_target = (bus.ex_rs + bus.ex_imm) & ~XLEN'(1);
            end
            default: w_taken = 1'b0;
        endcase
    end

    assign w_actual     = w_taken ? w_target : w_ex_pc4;
    assign w_mispredict = bus.ex_valid &&
                          ((w_taken != bus.ex_pred_taken) ||
                           (w_taken && (w_target != bus.ex_pred_target)));

    always_ff @(posedge clk) begin
        if (rst)                r_pc <= RESET_PC;
        else if (w_mispredict)  r_pc <= w_actual;
        else if (!bus.stall)    r_pc <= w_pred_taken ? w_pred_target
                                                     : r_pc + XLEN'(INSTR_BYTES);
    end

    assign bus.if_pc          = r_pc;
    assign bus.if_pred_taken  = w_pred_taken;
    assign bus.if_pred_target = w_pred_target;
    assign bus.redirect       = w_mispredict;
    assign bus.flush          = w_mispredict;
    assign bus.redirect_pc    = w_mispredict ? w_actual : '0;

endmodule
